// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux_n registered multiplexer.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never narrower than one bit.
  function automatic int selWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts just after 'last' and wraps.
module rr_arbiter #(
  parameter int N    = 5,
  parameter int SELW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[(int'(last) + k) % N]) begin
        w_found                   = 1'b1;
        gnt[(int'(last) + k) % N] = 1'b1;
        gnt_idx                   = SELW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel registered mux with fixed-select or round-robin arbitration and valid/ready handshake.
// Optional packet lock in round-robin mode is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  parameter int SELW  = selWidth(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic [WIDTH-1:0] r_outData;
  logic             r_outValid;
  logic [SELW-1:0]  r_outChan;
  logic [SELW-1:0]  r_last;

  logic             w_load;
  logic             w_accept;
  logic [N-1:0]     w_rrReq;
  logic [N-1:0]     w_rrGnt;
  logic [SELW-1:0]  w_rrIdx;
  logic [N-1:0]     w_fixedGrant;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grantIdx;
  logic [WIDTH-1:0] w_selData;

`ifdef ARB_MUX_LOCK_EN
  logic             r_locked;
  logic [SELW-1:0]  r_lockChan;

  // While a packet is open only its own channel may request the arbiter.
  assign w_rrReq = r_locked ? (in_valid & (N'(1) << r_lockChan)) : in_valid;
`else
  assign w_rrReq = in_valid;
`endif

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rrArbiter (
    .req     (w_rrReq),
    .last    (r_last),
    .gnt     (w_rrGnt),
    .gnt_idx (w_rrIdx)
  );

  // An out-of-range select matches no channel, so nothing is ever granted.
  always_comb begin
    w_fixedGrant = '0;
    for (int i = 0; i < N; i++) begin
      w_fixedGrant[i] = in_valid[i] && (sel == SELW'(i));
    end
  end

  assign w_grant    = (mode == MODE_RR) ? w_rrGnt : w_fixedGrant;
  assign w_grantIdx = (mode == MODE_RR) ? w_rrIdx : sel;
  assign w_load     = !r_outValid || out_ready;
  assign w_accept   = (|w_grant) && w_load;
  assign in_ready   = rst ? '0 : (w_grant & {N{w_load}});

  always_comb begin
    w_selData = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grantIdx == SELW'(i)) begin
        w_selData = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outChan  <= '0;
      r_last     <= SELW'(N - 1);
`ifdef ARB_MUX_LOCK_EN
      r_locked   <= 1'b0;
      r_lockChan <= '0;
`endif
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= w_selData;
      r_outChan  <= w_grantIdx;
      if (mode == MODE_RR) begin
        r_last     <= w_grantIdx;
`ifdef ARB_MUX_LOCK_EN
        r_locked   <= !in_last[w_grantIdx];
        r_lockChan <= w_grantIdx;
`endif
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign out_chan  = r_outChan;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed steps plus random traffic against a transaction-level model.
// Lock scenarios are exercised when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux_n;
  import arb_mux_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 5;
  localparam int SELW  = selWidth(N);

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;
`ifdef ARB_MUX_LOCK_EN
  logic [N-1:0]       in_last;
`endif

  logic [WIDTH-1:0] tbData [N];

  bit               mValid;
  logic [WIDTH-1:0] mData;
  int               mChan;
  int               mLast;
  bit               mLocked;
  int               mLockChan;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  // Channel that wins this cycle according to the selection rules, or -1.
  function automatic int expGrant();
    if (mode == MODE_FIXED) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    if (mLocked) return in_valid[mLockChan] ? mLockChan : -1;
    for (int k = 1; k <= N; k++) begin
      if (in_valid[(mLast + k) % N]) return (mLast + k) % N;
    end
    return -1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int g;
    bit load;
    logic [N-1:0] expReady;
    g        = expGrant();
    load     = !mValid || out_ready;
    expReady = (rst || g < 0 || !load) ? '0 : (N'(1) << g);
    checkVal("in_ready",  32'(in_ready),  32'(expReady));
    checkVal("out_valid", 32'(out_valid), 32'(mValid));
    checkVal("out_data",  out_data,       mData);
    checkVal("out_chan",  32'(out_chan),  32'(mChan));
  endtask

  task automatic updateModel();
    int g;
    bit load;
    if (rst) begin
      mValid = 0; mData = '0; mChan = 0; mLast = N - 1; mLocked = 0;
      return;
    end
    g    = expGrant();
    load = !mValid || out_ready;
    if (g >= 0 && load) begin
      mValid = 1;
      mData  = tbData[g];
      mChan  = g;
      if (mode == MODE_RR) begin
        mLast = g;
`ifdef ARB_MUX_LOCK_EN
        mLocked   = !in_last[g];
        mLockChan = g;
`endif
      end
    end else if (out_ready) begin
      mValid = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input int s, input logic [N-1:0] v,
                               input bit rdy, input logic [N-1:0] lst);
    @(negedge clk);
    rst       = r;
    mode      = m;
    sel       = SELW'(s);
    in_valid  = v;
    out_ready = rdy;
`ifdef ARB_MUX_LOCK_EN
    in_last   = lst;
`endif
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = tbData[i];
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
  endtask

  task automatic newData();
    for (int i = 0; i < N; i++) tbData[i] = $urandom;
  endtask

  task automatic cycle(input bit r, input bit m, input int s, input logic [N-1:0] v,
                       input bit rdy, input logic [N-1:0] lst);
    newData();
    applyStimulus(r, m, s, v, rdy, lst);
  endtask

  initial begin
    rst = 1'b1; mode = MODE_RR; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
`ifdef ARB_MUX_LOCK_EN
    in_last = '0;
`endif
    mValid = 0; mData = '0; mChan = 0; mLast = N - 1; mLocked = 0; mLockChan = 0;

    $display("[TB] reset with all channels valid");
    repeat (2) cycle(1, MODE_RR, 0, '1, 1, '0);

    $display("[TB] round robin, all valid, full throughput");
    repeat (10) cycle(0, MODE_RR, 0, '1, 1, '0);

    $display("[TB] fixed select ch2, then out-of-range select");
    newData(); tbData[2] = 32'hDEADBEEF;
    applyStimulus(0, MODE_FIXED, 2, '1, 1, '0);
    cycle(0, MODE_FIXED, 2, '1, 1, '0);
    repeat (3) cycle(0, MODE_FIXED, 7, '1, 1, '0);

    $display("[TB] backpressure then simultaneous drain and load");
    cycle(0, MODE_RR, 0, '1, 1, '0);
    repeat (3) cycle(0, MODE_RR, 0, '1, 0, '0);
    repeat (2) cycle(0, MODE_RR, 0, '1, 1, '0);

    $display("[TB] sparse requests with wrap");
    cycle(0, MODE_RR, 0, 5'b00010, 1, '0);
    repeat (2) cycle(0, MODE_RR, 0, 5'b10010, 1, '0);
    cycle(0, MODE_RR, 0, 5'b00000, 1, '0);

`ifdef ARB_MUX_LOCK_EN
    $display("[TB] packet lock on ch3");
    cycle(1, MODE_RR, 0, '0, 1, '0);
    cycle(0, MODE_RR, 0, 5'b01000, 1, 5'b00000);
    cycle(0, MODE_RR, 0, 5'b01001, 1, 5'b00000);
    cycle(0, MODE_RR, 0, 5'b01001, 1, 5'b01000);
    cycle(0, MODE_RR, 0, 5'b11001, 1, 5'b00000);
    cycle(1, MODE_RR, 0, '0, 1, '0);
    cycle(0, MODE_RR, 0, 5'b01000, 1, 5'b00000);
    cycle(1, MODE_RR, 0, 5'b01001, 1, 5'b00000);
    cycle(0, MODE_RR, 0, 5'b01001, 1, 5'b00000);
    cycle(0, MODE_RR, 0, 5'b01001, 1, 5'b00000);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            N'($urandom), $urandom_range(0, 3) != 0, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer for the multicycle datapath.
- Replaces fixed-width combinational selectors wherever several producers compete for one consumer, e.g. memory-port sharing and writeback source.
- Two modes: fixed select (software/FSM-driven channel) or round-robin arbitration.
- valid/ready handshake on every channel and on the single registered output.

Parameters:
- WIDTH, 32, data width per channel.
- N, 5, number of input channels (≥2).
- SELW, $clog2(N), width of select/channel-index fields.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i has data
- in_ready  out  N  channel i beat accepted this cycle (combinational)
- out_data  out  WIDTH  registered selected data
- out_valid  out  1  out_data holds an unconsumed beat
- out_ready  in  1  consumer accepts out_data
- out_chan  out  SELW  index of the channel that produced out_data

Behaviour:
- Reset values: out_valid=0, out_data=0, out_chan=0. RR pointer last=N-1, so channel 0 has first priority.
- Reset is synchronous, active-high. A pending output beat is discarded on reset. in_ready is forced to 0 while rst=1.
- load = !out_valid | out_ready. Single-stage buffer; full throughput of one beat per cycle when out_ready=1.
- grant (one-hot, N bits), computed combinationally each cycle:
  - Fixed mode: grant[sel]=in_valid[sel]. If sel≥N, grant=0; no channel is ever accepted (mirrors zero-default of out-of-range select).
  - RR mode: first i with in_valid[i]=1, searching last+1, last+2, … with wrap modulo N. If no channel is valid, grant=0.
- in_ready[i] = grant[i] & load & !rst.
- Accepted-beat update (any grant bit set and load=1): next cycle out_data=in_data of the granted channel, out_chan=its index, out_valid=1. In RR mode, last=index.
- No accept but out_ready=1: out_valid→0. out_data and out_chan hold their last values.
- Accept and out_ready in the same cycle: the old beat leaves and the new beat loads; out_valid stays 1.
- out_valid=1 and out_ready=0: out_data and out_chan are stable and in_ready=0 everywhere.
- Latency is one clock from input handshake to out_valid.
- mode and sel are sampled every cycle. Switching mode does not reset last. Fixed-mode accepts do not update last.
- No combinational path from in_valid/in_data to out_*. The only combinational path from out_ready is to in_ready.

Optional Feature:
- Macro ARB_MUX_LOCK_EN.
- Defined:
  - Adds port in_last (in, N bits), which marks the final beat of a packet.
  - In RR mode, after a beat from channel c with in_last[c]=0 is accepted, the grant is locked to c. Other channels are ignored until a beat from c with in_last[c]=1 is accepted; the lock then releases and last=c.
  - Fixed mode ignores the lock. rst clears the lock.
- Undefined: no in_last port; arbitration is re-evaluated on every beat.

Decomposition:
- Package arb_mux_pkg: constants MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a sel-width helper function.
- One sub-module, rr_arbiter: inputs req[N], last[SELW], outputs gnt[N] and gnt_idx[SELW]; purely combinational rotate-priority.
- Top level holds the pointer, the output register, handshake logic and (if enabled) the lock.

Test Plan:
- Reset: hold rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, in_ready=0; after release, RR accepts ch0 first.
- Fixed mode, sel=2, in_data ch2=32'hDEADBEEF, out_ready=1 → in_ready=5'b00100; next cycle out_data=DEADBEEF, out_chan=2. Set sel=7 → in_ready=0 forever, out_valid drops.
- RR, N=5, all valid, out_ready=1 for 10 cycles → out_chan sequence 0,1,2,3,4,0,1,2,3,4; one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles after a load → out_data and out_chan stable, in_ready=0; on out_ready=1, a simultaneous new load keeps out_valid=1 with no gap.
- RR with sparse requests: only ch1 and ch4 valid, last=1 → ch4 granted, then ch1 (wrap).
- ARB_MUX_LOCK_EN: ch3 sends 3 beats (in_last on the 3rd) while ch0 is valid → out_chan 3,3,3 then 4 if valid else 0; reset mid-packet clears the lock and ch0 wins.
